instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Upstream neighbour of the multicycle `Controller`. It owns the program counter and the instruction register (IR), and runs the request/grant/read-valid handshake to instruction memory. It decodes the `Op`/`Func` fields the controller consumes. It also applies the controller's `PCWrite`/`Branch`/`PCSrc` decisions to the PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports (`Clk` rising-edge; reset asynchronous, active-low):
- `Clk` in 1: system clock
- `Rst_n` in 1: async active-low reset
- `IRWrite` in 1: controller request to fetch the instruction at the current PC
- `PCWrite` in 1: unconditional PC update
- `Branch` in 1: conditional PC update
- `Zero` in 1: ALU zero flag
- `PCSrc` in 2: next-PC select
- `ALUResult` in 32: combinational ALU result
- `ALUOut` in 32: registered ALU result
- `mem_req` out 1: fetch request
- `mem_addr` out 32: fetch address, word aligned
- `mem_gnt` in 1: memory accepted the request
- `mem_rvalid` in 1: `mem_rdata` valid
- `mem_rdata` in 32: instruction word
- `Instr` out 32: IR contents
- `Op` out 6: `Instr[31:26]`
- `Func` out 6: `Instr[5:0]`
- `Instr_valid` out 1: one-cycle pulse when the IR is loaded
- `Fetch_busy` out 1: a fetch is outstanding; the controller holds its fetch state
- `PC` out 32: current PC
- `Misaligned` out 1: sticky misaligned-PC flag (only with the macro)

## Operation
- FSM states:
  - IDLE: on `IRWrite`, latch `mem_addr <= PC` and go to REQ.
  - REQ: `mem_req=1`; on `mem_gnt`, go to WAIT.
  - WAIT: on `mem_rvalid`, set `Instr <= mem_rdata`, pulse `Instr_valid` and go to IDLE.
- Gnt and rvalid in the same cycle while in REQ: the IR loads immediately and the FSM goes to IDLE.
- `Fetch_busy` = state != IDLE.
- `IRWrite` is ignored while busy. `mem_rvalid` is ignored outside WAIT (stale responses are dropped).
- `mem_addr` is registered at request time. A PC update during a fetch does not disturb the outstanding request.
- PC enable = `PCWrite | (Branch & Zero)`. Next PC by `PCSrc`:
  - 00: `ALUResult`
  - 01: `ALUOut`
  - 10: `{PC[31:28], Instr[25:0], 2'b00}`
  - 11: hold (no update)
- PC arithmetic (PC+4) is done by the ALU. This block performs no addition.
- If `IRWrite` and a PC update fall in the same cycle, the fetch uses the old PC.

## Timing
- Reset values:
  - PC = `RESET_PC`
  - Instr = 0, so Op = 0 and Func = 0
  - state IDLE
  - `mem_req` = 0, `mem_addr` = 0
  - `Instr_valid` = 0, `Fetch_busy` = 0, `Misaligned` = 0
- Minimum latency is 2 cycles: `IRWrite` at edge N, `mem_req` high N..N+1, gnt and rvalid at N+1, `Instr`/`Instr_valid` at N+2.
- `mem_req` stays high until `mem_gnt` is sampled. Memory stalls of any length are tolerated.
- A PC update takes effect at the edge after the enable is sampled.
- Reset mid-fetch: the FSM returns to IDLE asynchronously, `mem_req` drops, and the IR is not updated.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A PC load with `next_pc[1:0] != 0` is blocked (PC holds) and sets `Misaligned`, which stays set until reset.
  - `IRWrite` while `Misaligned` is set is ignored.
- Undefined: `Misaligned` is tied to 0 and `next_pc[1:0]` is forced to 00 on load.

## Structure
- Shared package `mips_pkg`:
  - `PCSrc` encodings: `PCSRC_ALU`, `PCSRC_ALUOUT`, `PCSRC_JUMP`, `PCSRC_HOLD`
  - opcode field positions
  - fetch FSM state enum
- One natural sub-module: `pc_reg`, holding the enable logic, the next-PC mux and the alignment check.

## Test plan
- Reset with `RESET_PC`=32'h0000_0040 -> PC=0x40, Op=0, Func=0, `mem_req`=0.
- `IRWrite`, gnt and rvalid same cycle, rdata=32'h0000_0009 -> Instr_valid pulse 2 cycles after `IRWrite`; Op=0, Func=6'b001001.
- gnt delayed 3 cycles, rvalid delayed 2 more -> `mem_req` held 4 cycles; `Fetch_busy` high throughout; a second `IRWrite` is ignored.
- `Branch=1`, `Zero=0`, `ALUOut`=0x100 -> PC unchanged. With `Zero=1` -> PC=0x100 next cycle.
- `PCSrc=10`, PC=0x4000_0010, Instr=0x0800_0004, `PCWrite` -> PC=0x4000_0010.
- With the macro: `PCWrite`, `ALUResult`=0x102 -> PC holds and `Misaligned`=1. Reset asserted mid-WAIT -> state IDLE, `Misaligned` cleared, late rvalid ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch path: PC source encodings,
// instruction field positions and the fetch FSM state enum.
package mips_pkg;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNC_MSB  = 5;
  localparam int FUNC_LSB  = 0;
  localparam int JADDR_MSB = 25;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: update enable, next-PC select and alignment policy.
// With FETCH_ALIGN_CHECK_EN defined, misaligned loads are blocked and flagged.
module pc_reg import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        branch,
  input  logic        zero,
  input  logic [1:0]  pc_src,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [25:0] jaddr,
  output logic [31:0] pc,
  output logic        misaligned
);

  logic [31:0] pc_q, pc_d, next_pc;
  logic        mis_q, mis_d;
  logic        pc_en;

  always_comb begin
    pc_en = (pc_write | (branch & zero)) && (pc_src != PCSRC_HOLD);
    case (pc_src)
      PCSRC_ALU:    next_pc = alu_result;
      PCSRC_ALUOUT: next_pc = alu_out;
      PCSRC_JUMP:   next_pc = {pc_q[31:28], jaddr, 2'b00};
      default:      next_pc = pc_q;
    endcase
    pc_d  = pc_q;
    mis_d = mis_q;
`ifdef FETCH_ALIGN_CHECK_EN
    // A bad target freezes the PC; the flag is sticky until reset.
    if (pc_en) begin
      if (next_pc[1:0] != 2'b00) mis_d = 1'b1;
      else                       pc_d  = next_pc;
    end
`else
    if (pc_en) pc_d = next_pc & ~32'h3;
    mis_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

  assign pc         = pc_q;
  assign misaligned = mis_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, instruction register and req/gnt/rvalid fetch FSM.
// Optional misaligned-PC checking is enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         IRWrite,
  input  logic         PCWrite,
  input  logic         Branch,
  input  logic         Zero,
  input  logic [1:0]   PCSrc,
  input  logic [31:0]  ALUResult,
  input  logic [31:0]  ALUOut,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_gnt,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata,
  output logic [31:0]  Instr,
  output logic [5:0]   Op,
  output logic [5:0]   Func,
  output logic         Instr_valid,
  output logic         Fetch_busy,
  output logic [31:0]  PC,
  output logic         Misaligned,
  output fetch_state_e dbg_state
);

  // Memory handshake: a request is held while mem_req=1 until mem_gnt is
  // sampled high; the word is taken on the first mem_rvalid at or after grant.
  fetch_state_e state_q, state_d;
  logic         mem_req_q, mem_req_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  pc;
  logic         misaligned;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .pc_write   (PCWrite),
    .branch     (Branch),
    .zero       (Zero),
    .pc_src     (PCSrc),
    .alu_result (ALUResult),
    .alu_out    (ALUOut),
    .jaddr      (instr_q[JADDR_MSB:0]),
    .pc         (pc),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        // The address is captured from the current (pre-update) PC.
        if (IRWrite && !misaligned) begin
          state_d    = FETCH_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = pc & ~32'h3;
        end
      end
      FETCH_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_rvalid) begin
            instr_d       = mem_rdata;
            instr_valid_d = 1'b1;
            state_d       = FETCH_IDLE;
          end else begin
            state_d = FETCH_WAIT;
          end
        end
      end
      FETCH_WAIT: begin
        if (mem_rvalid) begin
          instr_d       = mem_rdata;
          instr_valid_d = 1'b1;
          state_d       = FETCH_IDLE;
        end
      end
      default: begin
        state_d   = FETCH_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= FETCH_IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 32'h0;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign Instr       = instr_q;
  assign Op          = instr_q[OP_MSB:OP_LSB];
  assign Func        = instr_q[FUNC_MSB:FUNC_LSB];
  assign Instr_valid = instr_valid_q;
  assign Fetch_busy  = (state_q != FETCH_IDLE);
  assign PC          = pc;
  assign Misaligned  = misaligned;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit (RESET_PC = 0x40); honours
// FETCH_ALIGN_CHECK_EN when defined at compile time.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  logic         Clk, Rst_n;
  logic         IRWrite, PCWrite, Branch, Zero;
  logic [1:0]   PCSrc;
  logic [31:0]  ALUResult, ALUOut;
  logic         mem_req, mem_gnt, mem_rvalid;
  logic [31:0]  mem_addr, mem_rdata;
  logic [31:0]  Instr, PC;
  logic [5:0]   Op, Func;
  logic         Instr_valid, Fetch_busy, Misaligned;
  fetch_state_e dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] last_instr;

  instr_fetch_unit #(.RESET_PC(32'h0000_0040)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .Zero(Zero), .PCSrc(PCSrc), .ALUResult(ALUResult),
    .ALUOut(ALUOut), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .Instr(Instr), .Op(Op), .Func(Func), .Instr_valid(Instr_valid),
    .Fetch_busy(Fetch_busy), .PC(PC), .Misaligned(Misaligned),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every IR load must match the oldest expected word
  always @(negedge Clk) begin
    if (Rst_n && Instr_valid) begin
      logic [31:0] e;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got %h expected no load", Instr);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", Instr, e);
        chk("sb_op", {26'h0, Op}, {26'h0, e[31:26]});
        chk("sb_func", {26'h0, Func}, {26'h0, e[5:0]});
        last_instr = e;
      end
    end
  end

  // Driver: one fetch at exp_pc; poke re-asserts IRWrite while busy
  task automatic do_fetch(input logic [31:0] rdata, input int gnt_dly, input int rv_dly, input bit poke);
    logic [31:0] addr;
    addr = exp_pc & ~32'h3;
    IRWrite = 1'b1;
    exp_q.push_back(rdata);
    @(negedge Clk);
    IRWrite = 1'b0;
    chk("req_start", {31'h0, mem_req}, 32'h1);
    chk("req_addr", mem_addr, addr);
    chk("busy_req", {31'h0, Fetch_busy}, 32'h1);
    for (int i = 0; i < gnt_dly; i++) begin
      IRWrite = poke;
      @(negedge Clk);
      IRWrite = 1'b0;
      chk("req_hold", {31'h0, mem_req}, 32'h1);
      chk("busy_stall", {31'h0, Fetch_busy}, 32'h1);
    end
    mem_gnt = 1'b1;
    if (rv_dly == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
    end
    @(negedge Clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (rv_dly > 0) begin
      for (int i = 0; i < rv_dly; i++) begin
        chk("req_drop", {31'h0, mem_req}, 32'h0);
        chk("busy_wait", {31'h0, Fetch_busy}, 32'h1);
        IRWrite = poke;
        @(negedge Clk);
        IRWrite = 1'b0;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      @(negedge Clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hDEAD_BEEF;
    end
    chk("valid_pulse", {31'h0, Instr_valid}, 32'h1);
    chk("busy_done", {31'h0, Fetch_busy}, 32'h0);
    @(negedge Clk);
    chk("valid_once", {31'h0, Instr_valid}, 32'h0);
    chk("idle_after", {31'h0, Fetch_busy}, 32'h0);
  endtask

  task automatic pc_step(input logic pw, input logic [1:0] src, input logic [31:0] res);
    PCWrite = pw; PCSrc = src; ALUResult = res;
    @(negedge Clk);
    PCWrite = 1'b0; PCSrc = PCSRC_HOLD;
  endtask

  typedef struct {
    logic        pc_write;
    logic        branch;
    logic        zero;
    logic [1:0]  pc_src;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
    logic [31:0] exp_pc;
  } pc_vec_t;

  pc_vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, PCSRC_ALU,    32'h0000_0200, 32'h0,          32'h0000_0200};
    vecs[1] = '{1'b0, 1'b1, 1'b0, PCSRC_ALUOUT, 32'h0000_0300, 32'h0000_0100, 32'h0000_0200};
    vecs[2] = '{1'b0, 1'b1, 1'b1, PCSRC_ALUOUT, 32'h0000_0300, 32'h0000_0100, 32'h0000_0100};
    vecs[3] = '{1'b1, 1'b0, 1'b0, PCSRC_HOLD,   32'h0000_0300, 32'h0000_0500, 32'h0000_0100};
    vecs[4] = '{1'b0, 1'b0, 1'b1, PCSRC_ALU,    32'h0000_0500, 32'h0000_0600, 32'h0000_0100};
    vecs[5] = '{1'b1, 1'b1, 1'b0, PCSRC_ALUOUT, 32'h0000_0700, 32'h0000_0800, 32'h0000_0800};
    vecs[6] = '{1'b1, 1'b0, 1'b0, PCSRC_ALU,    32'h4000_0010, 32'h0,          32'h4000_0010};

    Rst_n = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0; Branch = 1'b0; Zero = 1'b0;
    PCSrc = PCSRC_HOLD; ALUResult = 32'h0; ALUOut = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    exp_pc = 32'h0000_0040; last_instr = 32'h0;
    repeat (2) @(negedge Clk);

    chk("rst_pc", PC, 32'h0000_0040);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_op_func", {20'h0, Op, Func}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_valid_busy", {30'h0, Instr_valid, Fetch_busy}, 32'h0);
    chk("rst_mis", {31'h0, Misaligned}, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(FETCH_IDLE));
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("post_rst_pc", PC, 32'h0000_0040);

    // Zero-stall fetch, then a stalled fetch with ignored IRWrite pokes
    do_fetch(32'h0000_0009, 0, 0, 1'b0);
    chk("op_after_fetch", {26'h0, Op}, 32'h0);
    chk("func_after_fetch", {26'h0, Func}, 32'h9);
    do_fetch(32'h8C22_0004, 3, 2, 1'b1);

    // Stale rvalid in IDLE is dropped
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge Clk);
    mem_rvalid = 1'b0;
    chk("stale_valid", {31'h0, Instr_valid}, 32'h0);
    chk("stale_instr", Instr, last_instr);

    // Table-driven PC updates
    for (int i = 0; i < 7; i++) begin
      PCWrite = vecs[i].pc_write; Branch = vecs[i].branch; Zero = vecs[i].zero;
      PCSrc = vecs[i].pc_src; ALUResult = vecs[i].alu_result; ALUOut = vecs[i].alu_out;
      @(negedge Clk);
      chk($sformatf("vec%0d_pc", i), PC, vecs[i].exp_pc);
      exp_pc = vecs[i].exp_pc;
    end
    PCWrite = 1'b0; Branch = 1'b0; Zero = 1'b0; PCSrc = PCSRC_HOLD;

    // Jump target built from PC[31:28] and the IR
    do_fetch(32'h0800_0004, 0, 0, 1'b0);
    pc_step(1'b1, PCSRC_JUMP, 32'h0);
    chk("jump_same", PC, 32'h4000_0010);
    do_fetch(32'h0800_0100, 1, 1, 1'b0);
    pc_step(1'b1, PCSRC_JUMP, 32'h0);
    chk("jump_new", PC, 32'h4000_0400);
    exp_pc = 32'h4000_0400;

    // IRWrite with a simultaneous PC update fetches from the old PC
    IRWrite = 1'b1; PCWrite = 1'b1; PCSrc = PCSRC_ALU; ALUResult = 32'h0000_0900;
    exp_q.push_back(32'h2108_0001);
    @(negedge Clk);
    IRWrite = 1'b0;
    chk("same_cyc_addr", mem_addr, 32'h4000_0400);
    chk("same_cyc_pc", PC, 32'h0000_0900);
    ALUResult = 32'h0000_0A00;
    @(negedge Clk);
    PCWrite = 1'b0; PCSrc = PCSRC_HOLD;
    chk("mid_fetch_addr", mem_addr, 32'h4000_0400);
    chk("mid_fetch_pc", PC, 32'h0000_0A00);
    chk("mid_fetch_req", {31'h0, mem_req}, 32'h1);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h2108_0001;
    @(negedge Clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("mid_fetch_valid", {31'h0, Instr_valid}, 32'h1);
    exp_pc = 32'h0000_0A00;

    // Random fetch traffic
    for (int k = 0; k < 6; k++) begin
      do_fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3), k[0]);
    end

    // Misaligned target during WAIT, then reset mid-fetch
    IRWrite = 1'b1;
    @(negedge Clk);
    IRWrite = 1'b0;
    mem_gnt = 1'b1;
    @(negedge Clk);
    mem_gnt = 1'b0;
    chk("wait_state", 32'(dbg_state), 32'(FETCH_WAIT));
    pc_step(1'b1, PCSRC_ALU, 32'h0000_0102);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_pc_hold", PC, 32'h0000_0A00);
    chk("mis_flag", {31'h0, Misaligned}, 32'h1);
`else
    chk("mis_pc_forced", PC, 32'h0000_0100);
    chk("mis_flag_off", {31'h0, Misaligned}, 32'h0);
`endif
    chk("mis_still_wait", 32'(dbg_state), 32'(FETCH_WAIT));
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(dbg_state), 32'(FETCH_IDLE));
    chk("arst_busy_req", {30'h0, Fetch_busy, mem_req}, 32'h0);
    chk("arst_mis", {31'h0, Misaligned}, 32'h0);
    chk("arst_pc", PC, 32'h0000_0040);
    @(negedge Clk);
    Rst_n = 1'b1;
    exp_pc = 32'h0000_0040;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge Clk);
    mem_rvalid = 1'b0;
    chk("late_rvalid_valid", {31'h0, Instr_valid}, 32'h0);
    chk("late_rvalid_instr", Instr, 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
    // IRWrite is ignored while the misaligned flag is set
    pc_step(1'b1, PCSRC_ALUOUT, 32'h0);
    ALUOut = 32'h0000_0203;
    pc_step(1'b1, PCSRC_ALUOUT, 32'h0);
    chk("mis2_flag", {31'h0, Misaligned}, 32'h1);
    IRWrite = 1'b1;
    @(negedge Clk);
    IRWrite = 1'b0;
    chk("mis2_no_fetch", {30'h0, Fetch_busy, mem_req}, 32'h0);
`endif

    chk("sb_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
